// File: rtl/conv_pkg.sv
// conv_pkg: tile geometry, tile types and scheduler states shared by the conv tile scheduler
package conv_pkg;
  localparam int TILE_IN = 6;
  localparam int TILE_OUT = 4;
  localparam int KERNEL = 3;
  typedef logic [0:TILE_IN-1][0:TILE_IN-1][7:0] tile_in_t;
  typedef logic [0:TILE_OUT-1][0:TILE_OUT-1][15:0] tile_out_t;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ENG_RST, S_ENG_START, S_CONV_WAIT, S_DRAIN, S_NEXT, S_DONE
  } sched_state_t;
endpackage

// File: rtl/conv_tile_fetch.sv
// conv_tile_fetch: issues the 36 window reads of one tile and assembles the 6x6 input window
module conv_tile_fetch import conv_pkg::*; #(
  parameter int IMG_W = 18,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output tile_in_t          tile,
  output logic              done
);
  logic rd_on, cap_on, last_rd;
  logic [2:0] rd_r, rd_c, cur_r, cur_c, cap_r, cap_c;
  // start issues read (0,0) in its own cycle so the fetch costs 36 reads plus one capture cycle
  always_comb begin
    cur_r = start ? '0 : rd_r;
    cur_c = start ? '0 : rd_c;
    mem_rd_en = start | rd_on;
    mem_addr = base + ADDR_W'(32'(cur_r) * IMG_W + 32'(cur_c));
    last_rd = cur_r == 3'(TILE_IN-1) && cur_c == 3'(TILE_IN-1);
    done = cap_on && cap_r == 3'(TILE_IN-1) && cap_c == 3'(TILE_IN-1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_on <= 1'b0;
      cap_on <= 1'b0;
      rd_r <= '0;
      rd_c <= '0;
      cap_r <= '0;
      cap_c <= '0;
      tile <= '0;
    end else begin
      if (mem_rd_en) begin
        rd_on <= !last_rd;
        rd_c <= cur_c == 3'(TILE_IN-1) ? '0 : cur_c + 3'd1;
        rd_r <= cur_c == 3'(TILE_IN-1) ? (last_rd ? '0 : cur_r + 3'd1) : cur_r;
      end
      cap_on <= mem_rd_en;
      cap_r <= cur_r;
      cap_c <= cur_c;
      if (cap_on) tile[cap_r][cap_c] <= mem_rd_data;
    end
  end
endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks a feature map tile by tile through the 4x4/3x3 conv engine and streams results
module conv_tile_scheduler import conv_pkg::*; #(
  parameter int IMG_W = 18,
  parameter int IMG_H = 18,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output tile_in_t          eng_tile,
  output logic              eng_rst_n,
  output logic              eng_start,
  input  logic              eng_done,
  input  tile_out_t         eng_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [7:0]        res_row,
  output logic [7:0]        res_col,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err_timeout
);
  localparam int TILES_X = (IMG_W - 2) / TILE_OUT;
  localparam int TILES_Y = (IMG_H - 2) / TILE_OUT;
  localparam int WW = $clog2(TIMEOUT + 1);
  sched_state_t state;
  logic [ADDR_W-1:0] base, tile_base;
  logic [7:0] tx, ty;
  logic [3:0] idx, nidx;
  logic [WW-1:0] wcnt;
  tile_out_t c_q;
  logic eng_rst_q, fetch_start, fetch_done, last_tile;
  // reset gates these two directly so they read low during reset and recover on the first cycle after
  always_comb begin
    cmd_ready = state == S_IDLE && !reset;
    eng_rst_n = eng_rst_q && !reset;
    tile_base = base + ADDR_W'(32'(ty) * TILE_OUT * IMG_W + 32'(tx) * TILE_OUT);
    last_tile = tx == 8'(TILES_X - 1) && ty == 8'(TILES_Y - 1);
    nidx = idx + 4'd1;
  end
  conv_tile_fetch #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_fetch (
    .clk(clk), .reset(reset), .start(fetch_start), .base(tile_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .tile(eng_tile), .done(fetch_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      base <= '0;
      tx <= '0;
      ty <= '0;
      idx <= '0;
      wcnt <= '0;
      c_q <= '0;
      eng_rst_q <= 1'b1;
      eng_start <= 1'b0;
      fetch_start <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_row <= '0;
      res_col <= '0;
      res_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      fetch_start <= 1'b0;
      eng_start <= 1'b0;
      eng_rst_q <= 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          state <= S_FETCH;
          base <= cmd_base;
          tx <= '0;
          ty <= '0;
          err_timeout <= 1'b0;
          busy <= 1'b1;
          fetch_start <= 1'b1;
        end
        S_FETCH: if (fetch_done) begin
          state <= S_ENG_RST;
          eng_rst_q <= 1'b0;
        end
        S_ENG_RST: begin
          state <= S_ENG_START;
          eng_start <= 1'b1;
        end
        S_ENG_START: begin
          state <= S_CONV_WAIT;
          wcnt <= WW'(1);
        end
        S_CONV_WAIT: if (eng_done) begin
          state <= S_DRAIN;
          c_q <= eng_c;
          idx <= '0;
          res_valid <= 1'b1;
          res_data <= eng_c[0][0];
          res_row <= {ty[5:0], 2'b00};
          res_col <= {tx[5:0], 2'b00};
          res_last <= 1'b0;
        end else if (wcnt == WW'(TIMEOUT)) begin
          state <= S_IDLE;
          err_timeout <= 1'b1;
          eng_rst_q <= 1'b0;
          busy <= 1'b0;
        end else wcnt <= wcnt + WW'(1);
        S_DRAIN: if (res_ready) begin
          if (idx == 4'd15) begin
            state <= S_NEXT;
            res_valid <= 1'b0;
            res_last <= 1'b0;
          end else begin
            idx <= nidx;
            res_data <= c_q[nidx[3:2]][nidx[1:0]];
            res_row <= {ty[5:0], nidx[3:2]};
            res_col <= {tx[5:0], nidx[1:0]};
            res_last <= last_tile && nidx == 4'd15;
          end
        end
        S_NEXT: begin
          if (tx == 8'(TILES_X - 1)) begin
            tx <= '0;
            ty <= ty + 8'd1;
          end else tx <= tx + 8'd1;
          state <= last_tile ? S_DONE : S_FETCH;
          fetch_start <= !last_tile;
          done <= last_tile;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: directed bench with ramp image memory and a behavioural 3x3 all-ones engine
module tb_conv_tile_scheduler;
  import conv_pkg::*;
  logic clk, reset, cmd_valid, cmd_ready, mem_rd_en, eng_rst_n, eng_start, eng_done;
  logic res_valid, res_ready, res_last, busy, done, err_timeout;
  logic [15:0] cmd_base, mem_addr, res_data;
  logic [7:0] mem_rd_data, res_row, res_col;
  tile_in_t eng_tile;
  tile_out_t eng_c;
  logic [7:0] mem [0:65535];
  logic [15:0] rd_log [0:1023];
  int n_checks = 0, n_fail = 0, done_cnt = 0, rd_n = 0, k = 0, eng_cnt = 0;
  bit rnd, eng_hang, mon_en, log_en;

  conv_tile_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .eng_tile(eng_tile),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_done(eng_done), .eng_c(eng_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
    .res_col(res_col), .res_last(res_last), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // result k of an image: tiles in raster order, 16 results per tile in raster order
  function automatic logic [32:0] exp_res(input int n);
    int t, i, r, c;
    t = n / 16;
    i = n % 16;
    r = 4 * (t / 4) + i / 4;
    c = 4 * (t % 4) + i % 4;
    return {16'(9 * (r + c + 2)), 8'(r), 8'(c), n == 255};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_done <= 1'b0;
      eng_cnt <= 0;
    end else if (eng_start) begin
      if (!eng_hang) eng_cnt <= 5;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          int s;
          s = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) s += int'(eng_tile[r+i][c+j]);
          eng_c[r][c] <= 16'(s);
        end
    end else if (eng_cnt == 1) begin
      eng_done <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (log_en && mem_rd_en && rd_n < 1024) begin
      rd_log[rd_n] = mem_addr;
      rd_n++;
    end
    if (mon_en && res_valid) begin
      check("result", {res_data, res_row, res_col, res_last}, exp_res(k));
      if (res_ready) k++;
    end
  end

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic load_img(input logic [15:0] b);
    for (int y = 0; y < 18; y++)
      for (int x = 0; x < 18; x++) mem[16'(b + 16'(y * 18 + x))] = 8'(x + y);
  endtask

  task automatic start_image(input logic [15:0] b);
    @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_base = b;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt);
    bit seen;
    seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", seen, 1);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, exp_cnt);
    check("result_count", k, 256);
    check("idle_after_done", {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_base = '0;
    rnd = 0;
    eng_hang = 0;
    mon_en = 0;
    log_en = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_eng_rst_n", eng_rst_n, 0);
    check("rst_mem", {mem_rd_en, mem_addr}, 0);
    check("rst_tile", |eng_tile, 0);
    check("rst_res", {eng_start, res_valid, res_data, res_row, res_col, res_last}, 0);
    check("rst_status", {busy, done, err_timeout}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_eng_rst_n", eng_rst_n, 1);

    // image at base 0 with read-address logging
    load_img(16'h0000);
    log_en = 1;
    mon_en = 1;
    k = 0;
    start_image(16'h0000);
    wait_done(1);
    log_en = 0;
    check("reads_total", rd_n, 576);
    check("rd_t0_first", rd_log[0], 0);
    check("rd_t0_last", rd_log[35], 95);
    check("rd_t1_first", rd_log[36], 4);
    check("rd_t1_second", rd_log[37], 5);
    check("rd_t1_last", rd_log[71], 99);
    check("rd_t2_first", rd_log[72], 8);
    check("last_tile_00", eng_tile[0][0], 24);
    check("last_tile_55", eng_tile[5][5], 34);

    // random backpressure plus a command pulsed while busy
    load_img(16'h0100);
    rnd = 1;
    k = 0;
    start_image(16'h0100);
    repeat (100) @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_base = 16'h4000;
    @(negedge clk);
    check("busy_cmd_ready", cmd_ready, 0);
    check("busy_high", busy, 1);
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(2);
    rnd = 0;

    // engine never finishes
    eng_hang = 1;
    k = 0;
    start_image(16'h0100);
    n = -1;
    for (int i = 0; i < 200 && n < 0; i++) begin
      @(negedge clk);
      if (eng_start) n = 0;
    end
    for (int i = 0; i < 400 && !err_timeout; i++) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 257);
    check("timeout_err", err_timeout, 1);
    check("timeout_idle", {busy, cmd_ready}, 2'b01);
    check("timeout_eng_rst", eng_rst_n, 0);
    repeat (3) @(negedge clk);
    check("timeout_no_done", done_cnt, 2);
    check("timeout_no_results", k, 0);
    check("timeout_sticky", err_timeout, 1);
    eng_hang = 0;
    start_image(16'h0100);
    @(negedge clk);
    check("err_cleared", err_timeout, 0);
    wait_done(3);

    // reset during DRAIN of tile 3
    k = 0;
    start_image(16'h0100);
    for (int i = 0; i < 3000 && k < 50; i++) @(negedge clk);
    check("reached_tile3", k >= 50 && k < 64, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_eng_rst_n", eng_rst_n, 0);
    repeat (3) @(negedge clk);
    check("midrst_held", {eng_rst_n, mem_rd_en, res_valid}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_no_done", done_cnt, 3);
    k = 0;
    mon_en = 1;
    start_image(16'h0100);
    wait_done(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
